alu_pipe: RTL and testbench

//   Parametrised, handshaked ALU: next generation of the single-cycle alu.

---
 rtl/alu_pipe.sv | 147 ++++++++++++++
 tb/tb_alu_pipe.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Handshaked ALU with zero/overflow/error flags and an iterative shift-add multiplier.
// One operation in flight; non-MUL ops complete in one cycle, MUL in WIDTH cycles.
module alu_pipe #(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       o,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             c,
  output logic             bo,
  output logic             z,
  output logic             ov,
  output logic             err
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
    OP_XOR = 4'd4, OP_SHL = 4'd5, OP_SHR = 4'd6, OP_MUL = 4'd7
  } op_e;

  typedef enum logic {ST_IDLE, ST_MUL} state_e;

  typedef struct packed {
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             c;
    logic             bo;
    logic             z;
    logic             ov;
    logic             err;
  } res_t;

  state_e             state, state_next;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] mcand, acc, acc_step;
  logic [WIDTH-1:0]   mplier;
  res_t               res_q, alu_res, mul_res;
  logic               accept, is_mul, mul_done, load;
  logic [WIDTH:0]     sum, diff;
  logic [SW-1:0]      shamt;

  assign in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = MUL_EN && (o == OP_MUL);
  assign mul_done = (state == ST_MUL) && (cnt == CW'(1));
  assign load     = (accept && !is_mul) || mul_done;

  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} - {1'b0, b};
  assign shamt = b[SW-1:0];

  // Final step's partial product is folded in combinationally so the result lands on the cnt==1 edge.
  assign acc_step = acc + (mplier[0] ? mcand : '0);
  assign mul_res  = '{hi: acc_step[2*WIDTH-1:WIDTH], lo: acc_step[WIDTH-1:0],
                      c: 1'b0, bo: 1'b0, z: (acc_step == '0), ov: 1'b0, err: 1'b0};

  // NOTE: every field gets a default before the case so no latch is inferred.
  always_comb begin
    alu_res = '0;
    case (o)
      OP_ADD: begin
        alu_res.lo = sum[WIDTH-1:0];
        alu_res.c  = sum[WIDTH];
        alu_res.ov = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res.lo = diff[WIDTH-1:0];
        alu_res.bo = diff[WIDTH];
        alu_res.ov = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_res.lo = a & b;
      OP_OR:   alu_res.lo = a | b;
      OP_XOR:  alu_res.lo = a ^ b;
      OP_SHL:  alu_res.lo = a << shamt;
      OP_SHR:  alu_res.lo = a >> shamt;
      default: alu_res.err = 1'b1;  // opcodes 8-15, and opcode 7 when MUL_EN=0
    endcase
    alu_res.z = ({alu_res.hi, alu_res.lo} == '0);
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept && is_mul) state_next = ST_MUL;
      ST_MUL:  if (cnt == CW'(1))    state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // NOTE: multiplier registers are reset too, so an aborted MUL leaves nothing stale behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      res_q     <= '0;
      cnt       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        res_q     <= mul_done ? mul_res : alu_res;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (accept && is_mul) begin
        mcand  <= {{WIDTH{1'b0}}, a};
        mplier <= b;
        acc    <= '0;
        cnt    <= CW'(WIDTH);
      end else if (state == ST_MUL) begin
        acc    <= acc_step;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - CW'(1);
      end
    end
  end

  assign result    = res_q.lo;
  assign result_hi = res_q.hi;
  assign c         = res_q.c;
  assign bo        = res_q.bo;
  assign z         = res_q.z;
  assign ov        = res_q.ov;
  assign err       = res_q.err;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe (WIDTH=8): arithmetic flags, logic/shift ops, MUL latency,
// output hold under backpressure, reset during MUL, illegal opcodes and MUL_EN=0.
module tb_alu_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_valid_nm, out_ready;
  logic [7:0] a, b;
  logic [3:0] o;

  logic       in_ready, out_valid, c, bo, z, ov, err;
  logic [7:0] result, result_hi;
  logic       in_ready_nm, out_valid_nm, c_nm, bo_nm, z_nm, ov_nm, err_nm;
  logic [7:0] result_nm, result_hi_nm;

  // Packed view: {out_valid, result_hi, result, c, bo, z, ov, err}
  logic [21:0] obs, obs_nm;
  assign obs    = {out_valid, result_hi, result, c, bo, z, ov, err};
  assign obs_nm = {out_valid_nm, result_hi_nm, result_nm, c_nm, bo_nm, z_nm, ov_nm, err_nm};

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(8), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .o(o), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi), .c(c), .bo(bo), .z(z), .ov(ov), .err(err)
  );

  alu_pipe #(.WIDTH(8), .MUL_EN(1'b0)) dut_nm (
    .clk(clk), .rst(rst), .in_valid(in_valid_nm), .in_ready(in_ready_nm),
    .a(a), .b(b), .o(o), .out_valid(out_valid_nm), .out_ready(out_ready),
    .result(result_nm), .result_hi(result_hi_nm), .c(c_nm), .bo(bo_nm), .z(z_nm),
    .ov(ov_nm), .err(err_nm)
  );

  // Presents one op to the main DUT for a single accept edge.
  task automatic issue(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
    o = op; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if (obs !== 22'h0) begin
      bad++; $display("FAIL reset_outputs got=%h exp=%h", obs, 22'h0);
    end
    total++;
    if (obs_nm !== 22'h0) begin
      bad++; $display("FAIL reset_outputs_nm got=%h exp=%h", obs_nm, 22'h0);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_arith();
    issue(4'd0, 8'hFF, 8'h01);
    total++;
    if (obs !== {1'b1, 8'h00, 8'h00, 5'b10100}) begin
      bad++; $display("FAIL add_ff_01 got=%h exp=%h", obs, {1'b1, 8'h00, 8'h00, 5'b10100});
    end
    issue(4'd1, 8'h10, 8'h20);
    total++;
    if (obs !== {1'b1, 8'h00, 8'hF0, 5'b01000}) begin
      bad++; $display("FAIL sub_10_20 got=%h exp=%h", obs, {1'b1, 8'h00, 8'hF0, 5'b01000});
    end
    issue(4'd0, 8'h7F, 8'h01);
    total++;
    if (obs !== {1'b1, 8'h00, 8'h80, 5'b00010}) begin
      bad++; $display("FAIL add_7f_01 got=%h exp=%h", obs, {1'b1, 8'h00, 8'h80, 5'b00010});
    end
    issue(4'd1, 8'h80, 8'h01);
    total++;
    if (obs !== {1'b1, 8'h00, 8'h7F, 5'b00010}) begin
      bad++; $display("FAIL sub_80_01 got=%h exp=%h", obs, {1'b1, 8'h00, 8'h7F, 5'b00010});
    end
  endtask

  // Issued with no idle cycles between ops: each result must appear the cycle after its accept.
  task automatic test_back_to_back();
    logic [3:0]  ops [6] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd6};
    logic [7:0]  xa  [6] = '{8'hF0, 8'hF0, 8'hAA, 8'h81, 8'h81, 8'h81};
    logic [7:0]  yb  [6] = '{8'h3C, 8'h0F, 8'hFF, 8'h08, 8'h07, 8'h09};
    logic [7:0]  exp [6] = '{8'h30, 8'hFF, 8'h55, 8'h81, 8'h01, 8'h40};
    for (int i = 0; i < 6; i++) begin
      total++;
      if (in_ready !== 1'b1) begin
        bad++; $display("FAIL b2b_ready[%0d] got=%b exp=1", i, in_ready);
      end
      issue(ops[i], xa[i], yb[i]);
      total++;
      if (obs !== {1'b1, 8'h00, exp[i], 5'b00000}) begin
        bad++; $display("FAIL b2b_op[%0d] got=%h exp=%h", i, obs, {1'b1, 8'h00, exp[i], 5'b00000});
      end
    end
  endtask

  task automatic run_mul(input logic [7:0] x, input logic [7:0] y, input logic [21:0] exp,
                         input string name);
    issue(4'd7, x, y);
    for (int i = 0; i < 8; i++) begin
      total++;
      if ({in_ready, out_valid} !== 2'b00) begin
        bad++; $display("FAIL %s_busy[%0d] got=%b exp=00", name, i, {in_ready, out_valid});
      end
      @(posedge clk); #1;
    end
    total++;
    if (obs !== exp) begin
      bad++; $display("FAIL %s_result got=%h exp=%h", name, obs, exp);
    end
  endtask

  task automatic test_mul();
    run_mul(8'hFF, 8'hFF, {1'b1, 8'hFE, 8'h01, 5'b00000}, "mul_ff_ff");
    run_mul(8'h12, 8'h34, {1'b1, 8'h03, 8'hA8, 5'b00000}, "mul_12_34");
    run_mul(8'h00, 8'h05, {1'b1, 8'h00, 8'h00, 5'b00100}, "mul_00_05");
  endtask

  task automatic test_hold();
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(4'd0, 8'h03, 8'h04);
    o = 4'd4; a = 8'h0F; b = 8'hF0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({in_ready, obs} !== {1'b0, 1'b1, 8'h00, 8'h07, 5'b00000}) begin
        bad++; $display("FAIL hold[%0d] got=%h exp=%h", i, {in_ready, obs},
                        {1'b0, 1'b1, 8'h00, 8'h07, 5'b00000});
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL hold_release_ready got=%b exp=1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if (obs !== {1'b1, 8'h00, 8'hFF, 5'b00000}) begin
      bad++; $display("FAIL hold_xor got=%h exp=%h", obs, {1'b1, 8'h00, 8'hFF, 5'b00000});
    end
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL hold_drain got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_reset_mid_mul();
    logic seen;
    issue(4'd0, 8'h20, 8'h01);
    issue(4'd7, 8'h12, 8'h34);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    total++;
    if ({in_ready, obs} !== {1'b1, 22'h0}) begin
      bad++; $display("FAIL midmul_reset got=%h exp=%h", {in_ready, obs}, {1'b1, 22'h0});
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b0 || in_ready !== 1'b1) seen = 1'b1;
      @(posedge clk); #1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++; $display("FAIL midmul_stale got=%b exp=0", seen);
    end
    issue(4'd0, 8'h01, 8'h01);
    total++;
    if (obs !== {1'b1, 8'h00, 8'h02, 5'b00000}) begin
      bad++; $display("FAIL midmul_add got=%h exp=%h", obs, {1'b1, 8'h00, 8'h02, 5'b00000});
    end
  endtask

  task automatic test_illegal();
    issue(4'hA, 8'h55, 8'hAA);
    total++;
    if (obs !== {1'b1, 8'h00, 8'h00, 5'b00101}) begin
      bad++; $display("FAIL illegal_a got=%h exp=%h", obs, {1'b1, 8'h00, 8'h00, 5'b00101});
    end
    issue(4'hF, 8'hFF, 8'hFF);
    total++;
    if (obs !== {1'b1, 8'h00, 8'h00, 5'b00101}) begin
      bad++; $display("FAIL illegal_f got=%h exp=%h", obs, {1'b1, 8'h00, 8'h00, 5'b00101});
    end
    o = 4'd7; a = 8'h03; b = 8'h05; in_valid_nm = 1'b1;
    @(posedge clk); #1;
    in_valid_nm = 1'b0;
    total++;
    if (obs_nm !== {1'b1, 8'h00, 8'h00, 5'b00101}) begin
      bad++; $display("FAIL nomul_err got=%h exp=%h", obs_nm, {1'b1, 8'h00, 8'h00, 5'b00101});
    end
    total++;
    if (in_ready_nm !== 1'b1) begin
      bad++; $display("FAIL nomul_ready got=%b exp=1", in_ready_nm);
    end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_valid_nm = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; o = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_arith();
    test_back_to_back();
    test_mul();
    test_hold();
    test_reset_mid_mul();
    test_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
